// File: rtl/accel_pkg.sv
// Shared types and defaults for the accelerometer boxcar filter.
package accel_pkg;

  localparam int ACCEL_DATA_W     = 10;
  localparam int ACCEL_LOG2_DEPTH = 3;

  typedef logic signed [ACCEL_DATA_W-1:0] accel_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } fill_state_e;

endpackage

// File: rtl/accel_axis_avg.sv
// One axis of the boxcar filter: circular history, running window sum and
// registered floor-mean output. Write pointer and accept strobe come from the top.
module accel_axis_avg #(
  parameter int DATA_W     = 10,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_accept,
  input  logic [LOG2_DEPTH-1:0]    i_wr_ptr,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_avg
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = DATA_W + LOG2_DEPTH;

  logic signed [DATA_W-1:0] hist_r [DEPTH];
  logic signed [SUM_W-1:0]  sum_r;
  logic signed [DATA_W-1:0] avg_r;

  logic signed [DATA_W-1:0] oldest_s;
  logic signed [SUM_W-1:0]  new_ext_s;
  logic signed [SUM_W-1:0]  old_ext_s;
  logic signed [SUM_W-1:0]  next_sum_s;
  logic signed [DATA_W-1:0] avg_next_s;

  // Window update: add the incoming sample, drop the one it overwrites.
  always_comb begin
    oldest_s   = hist_r[i_wr_ptr];
    new_ext_s  = {{LOG2_DEPTH{i_data[DATA_W-1]}}, i_data};
    old_ext_s  = {{LOG2_DEPTH{oldest_s[DATA_W-1]}}, oldest_s};
    next_sum_s = sum_r + new_ext_s - old_ext_s;
    // Dropping the low bits of a two's complement sum is an arithmetic
    // shift, i.e. floor toward -inf; the window sum always fits DATA_W after it.
    avg_next_s = next_sum_s[SUM_W-1:LOG2_DEPTH];
  end

  // History, sum and output registers; clear has priority over a new sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i] <= {DATA_W{1'b0}};
      end
      sum_r <= {SUM_W{1'b0}};
      avg_r <= {DATA_W{1'b0}};
    end else if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i] <= {DATA_W{1'b0}};
      end
      sum_r <= {SUM_W{1'b0}};
      avg_r <= {DATA_W{1'b0}};
    end else if (i_accept) begin
      hist_r[i_wr_ptr] <= i_data;
      sum_r            <= next_sum_s;
      avg_r            <= avg_next_s;
    end else begin
      sum_r <= sum_r;
      avg_r <= avg_r;
    end
  end

  assign o_avg = avg_r;

endmodule

// File: rtl/accel_avg_filter.sv
// Three-axis moving-average filter for ADXL345 samples; shared write pointer,
// fill tracking and valid/primed flags live here, per-axis datapaths below.
module accel_avg_filter
  import accel_pkg::*;
#(
  parameter int DATA_W     = ACCEL_DATA_W,
  parameter int LOG2_DEPTH = ACCEL_LOG2_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic signed [DATA_W-1:0] i_data_x,
  input  logic signed [DATA_W-1:0] i_data_y,
  input  logic signed [DATA_W-1:0] i_data_z,
  input  logic                     i_data_valid,
  output logic signed [DATA_W-1:0] o_avg_x,
  output logic signed [DATA_W-1:0] o_avg_y,
  output logic signed [DATA_W-1:0] o_avg_z,
  output logic                     o_avg_valid,
  output logic                     o_primed
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;

  logic                  accept_s;
  logic [LOG2_DEPTH-1:0] wr_ptr_r;
  logic [CNT_W-1:0]      fill_cnt_r;
  fill_state_e           state_r;
  fill_state_e           next_state_s;
  logic                  avg_valid_r;
  logic                  primed_r;

  assign accept_s = i_data_valid & ~i_clear;

  // Shared write pointer and saturating count of accepted samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r   <= {LOG2_DEPTH{1'b0}};
      fill_cnt_r <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      wr_ptr_r   <= {LOG2_DEPTH{1'b0}};
      fill_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      wr_ptr_r <= wr_ptr_r + LOG2_DEPTH'(1);
      if (fill_cnt_r != CNT_W'(DEPTH)) begin
        fill_cnt_r <= fill_cnt_r + CNT_W'(1);
      end else begin
        fill_cnt_r <= fill_cnt_r;
      end
    end else begin
      wr_ptr_r   <= wr_ptr_r;
      fill_cnt_r <= fill_cnt_r;
    end
  end

  // Fill/run state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= FILL;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state: leave FILL on the DEPTH-th accepted sample, return on clear.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FILL: begin
        if (accept_s && (fill_cnt_r == CNT_W'(DEPTH - 1))) begin
          next_state_s = RUN;
        end else begin
          next_state_s = FILL;
        end
      end
      RUN: begin
        if (i_clear) begin
          next_state_s = FILL;
        end else begin
          next_state_s = RUN;
        end
      end
      default: next_state_s = FILL;
    endcase
  end

  // Output flags; primed tracks the next state so it rises with the DEPTH-th valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      avg_valid_r <= 1'b0;
      primed_r    <= 1'b0;
    end else begin
      avg_valid_r <= accept_s;
      primed_r    <= (next_state_s == RUN);
    end
  end

  assign o_avg_valid = avg_valid_r;
  assign o_primed    = primed_r;

  accel_axis_avg #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_axis_x (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (i_clear),
    .i_accept (accept_s),
    .i_wr_ptr (wr_ptr_r),
    .i_data   (i_data_x),
    .o_avg    (o_avg_x)
  );

  accel_axis_avg #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_axis_y (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (i_clear),
    .i_accept (accept_s),
    .i_wr_ptr (wr_ptr_r),
    .i_data   (i_data_y),
    .o_avg    (o_avg_y)
  );

  accel_axis_avg #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_axis_z (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (i_clear),
    .i_accept (accept_s),
    .i_wr_ptr (wr_ptr_r),
    .i_data   (i_data_z),
    .o_avg    (o_avg_z)
  );

endmodule

// File: tb/tb_accel_avg_filter.sv
// Self-checking bench for accel_avg_filter: directed tables plus random traffic
// against a queue-based mean-of-last-8 reference.
module tb_accel_avg_filter;

  localparam int DW    = 10;
  localparam int LD    = 3;
  localparam int DEPTH = 8;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_clear;
  logic                 i_data_valid;
  logic signed [DW-1:0] i_data_x, i_data_y, i_data_z;
  logic signed [DW-1:0] o_avg_x, o_avg_y, o_avg_z;
  logic                 o_avg_valid;
  logic                 o_primed;

  int total = 0;
  int bad   = 0;

  // reference model state
  int hx[$];
  int hy[$];
  int hz[$];
  int m_ax, m_ay, m_az;
  bit m_valid, m_primed;

  typedef struct {
    int x;
    int exp_x;
    bit exp_primed;
  } vec_t;
  vec_t tbl[17];

  accel_avg_filter #(.DATA_W(DW), .LOG2_DEPTH(LD)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .i_data_x     (i_data_x),
    .i_data_y     (i_data_y),
    .i_data_z     (i_data_z),
    .i_data_valid (i_data_valid),
    .o_avg_x      (o_avg_x),
    .o_avg_y      (o_avg_y),
    .o_avg_z      (o_avg_z),
    .o_avg_valid  (o_avg_valid),
    .o_primed     (o_primed)
  );

  always #5 i_clk = ~i_clk;

  function automatic int floor_div(int s, int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int win_avg(int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return floor_div(s, DEPTH);
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hx.delete(); hy.delete(); hz.delete();
    m_ax = 0; m_ay = 0; m_az = 0;
    m_valid = 1'b0; m_primed = 1'b0;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".avg_x"},  o_avg_x, m_ax);
    chk({tag, ".avg_y"},  o_avg_y, m_ay);
    chk({tag, ".avg_z"},  o_avg_z, m_az);
    chk({tag, ".valid"},  int'(o_avg_valid), int'(m_valid));
    chk({tag, ".primed"}, int'(o_primed), int'(m_primed));
  endtask

  task automatic push(ref int q[$], input int v);
    q.push_back(v);
    if (q.size() > DEPTH) void'(q.pop_front());
  endtask

  task automatic step(string tag, bit clr, bit vld, int x, int y, int z);
    i_clear      = clr;
    i_data_valid = vld;
    i_data_x     = DW'(x);
    i_data_y     = DW'(y);
    i_data_z     = DW'(z);
    @(posedge i_clk);
    #1;
    if (clr) begin
      model_reset();
    end else if (vld) begin
      push(hx, x); push(hy, y); push(hz, z);
      m_ax = win_avg(hx); m_ay = win_avg(hy); m_az = win_avg(hz);
      m_valid = 1'b1;
      if (hx.size() == DEPTH) m_primed = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    check_all(tag);
  endtask

  initial begin
    // test 2 table: X=100 x9 then 0 x8
    for (int i = 0; i < 17; i++) begin
      tbl[i].x = (i < 9) ? 100 : 0;
      tbl[i].exp_primed = (i >= 7);
    end
    tbl[0].exp_x  = 12;  tbl[1].exp_x  = 25;  tbl[2].exp_x  = 37;
    tbl[3].exp_x  = 50;  tbl[4].exp_x  = 62;  tbl[5].exp_x  = 75;
    tbl[6].exp_x  = 87;  tbl[7].exp_x  = 100; tbl[8].exp_x  = 100;
    tbl[9].exp_x  = 87;  tbl[10].exp_x = 75;  tbl[11].exp_x = 62;
    tbl[12].exp_x = 50;  tbl[13].exp_x = 37;  tbl[14].exp_x = 25;
    tbl[15].exp_x = 12;  tbl[16].exp_x = 0;

    i_rst = 1'b1; i_clear = 1'b0; i_data_valid = 1'b0;
    i_data_x = '0; i_data_y = '0; i_data_z = '0;
    model_reset();
    #12;
    i_rst = 1'b0;
    #1;
    check_all("reset");

    // test 1: async reset mid-stream
    step("pre", 1'b0, 1'b1, 200, -100, 300);
    step("pre", 1'b0, 1'b1, 200, -100, 300);
    step("pre", 1'b0, 1'b1, 200, -100, 300);
    #2;
    i_rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    i_data_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    step("t1", 1'b0, 1'b1, 80, 0, 0);
    chk("t1_first80", o_avg_x, 10);

    // test 2: table-driven ramp up and eviction
    step("t2clr", 1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      step("t2", 1'b0, 1'b1, tbl[i].x, 0, 0);
      chk("t2_tbl_x", o_avg_x, tbl[i].exp_x);
      chk("t2_tbl_primed", int'(o_primed), int'(tbl[i].exp_primed));
    end

    // test 3: floor of negative mean
    step("t3clr", 1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step("t3", 1'b0, 1'b1, -1, -1, -1);
      chk("t3_neg1", o_avg_x, -1);
    end

    // test 4: full-scale extremes
    step("t4clr", 1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step("t4p", 1'b0, 1'b1, 511, 511, 511);
    chk("t4_max_x", o_avg_x, 511);
    chk("t4_max_z", o_avg_z, 511);
    for (int i = 0; i < 8; i++) step("t4n", 1'b0, 1'b1, -512, -512, -512);
    chk("t4_min_x", o_avg_x, -512);
    chk("t4_min_y", o_avg_y, -512);

    // test 5: back-to-back valid for 20 cycles, pointer wraps twice
    step("t5clr", 1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step("t5", 1'b0, 1'b1, i * 25 - 250, i * 7, -i * 20);
      chk("t5_valid", int'(o_avg_valid), 1);
    end
    step("t5end", 1'b0, 1'b0, 0, 0, 0);
    chk("t5_valid_drop", int'(o_avg_valid), 0);

    // test 6: clear coincident with valid while in RUN
    chk("t6_in_run", int'(o_primed), 1);
    step("t6", 1'b1, 1'b1, 100, 100, 100);
    chk("t6_no_valid", int'(o_avg_valid), 0);
    chk("t6_unprimed", int'(o_primed), 0);
    step("t6b", 1'b0, 1'b1, 40, 40, 40);
    chk("t6_after40", o_avg_x, 5);

    // random traffic against the reference
    for (int n = 0; n < 400; n++) begin
      step("rnd",
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 1023)) - 512,
           int'($urandom_range(0, 1023)) - 512,
           int'($urandom_range(0, 1023)) - 512);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
